// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - MD_* : 2-bit encodings of the mult/div operation decoded in ID.
//   - REG_ZERO : architectural $0, which never creates a dependency.
//   - md_state_t : states of the HI/LO unit scheduler.
//   - reg_match : true when a producer register feeds an operand read in ID.
package pipe_pkg;

  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;
  localparam logic [1:0] MD_READ = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // A producer only matters if it is not $0 and the ID instruction actually
  // reads the matching source field.
  function automatic logic reg_match(
    input logic [4:0] r,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       use_rs,
    input logic       use_rt
  );
    return (r != REG_ZERO) && ((use_rs && (r == rs)) || (use_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_sched.sv
// HI/LO multiply/divide scheduler: a two-state FSM with a busy counter.
// Ports:
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_md_op          : mult/div operation decoded in ID (pipe_pkg MD_*)
//   i_hold           : stall from a non-MD source; a held mult/div must not issue
//   o_md_start       : one-cycle pulse when a mult/div is actually issued
//   o_md_busy        : unit busy, taken straight from the state register
//   o_state          : current FSM state, for observation
module md_sched
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_md_op,
  input  logic       i_hold,
  output logic       o_md_start,
  output logic       o_md_busy,
  output md_state_t  o_state
);

  md_state_t        r_state;
  md_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_md_start  = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (!i_reset && !i_hold && ((i_md_op == MD_MULT) || (i_md_op == MD_DIV))) begin
          o_md_start  = 1'b1;
          w_state_nxt = MD_BUSY;
          // Counter holds the remaining busy cycles after this issue cycle.
          w_cnt_nxt   = (i_md_op == MD_MULT) ? CNT_W'(MULT_CYCLES - 1)
                                             : CNT_W'(DIV_CYCLES - 1);
        end
      end
      MD_BUSY: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = MD_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = MD_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_md_busy = (r_state == MD_BUSY);
  assign o_state   = r_state;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Decides each cycle whether PC and IF/ID advance or hold, whether ID/EX gets a
// bubble, and qualifies the ID-resolved branch. All decisions are
// combinational; only the mult/div scheduler holds state.
// Ports:
//   i_clk, i_reset              : clock, synchronous active-high reset
//   i_id_*                      : fields of the instruction in ID
//   i_branch_ok                 : raw branch-taken from the ID comparator
//   i_ex_*, i_mem_*             : producer information from EX and MEM
//   o_pc_write                  : PC loads its next value
//   o_hazard                    : IF/ID holds (load-use or mult/div)
//   o_branch_bubble             : IF/ID holds only because a branch waits on operands
//   o_branch_go                 : branch-taken qualified by the absence of any stall
//   o_id_ex_bubble              : ID/EX loads a NOP
//   o_md_start, o_md_busy       : mult/div issue pulse and busy flag
//   o_md_state                  : mult/div scheduler state, for observation
// i_id_jump is accepted for interface completeness: jumps are held only through
// the generic stall, and their IF/ID flush belongs to the IF/ID block.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_use_rs,
  input  logic       i_id_use_rt,
  input  logic       i_id_is_branch,
  input  logic [1:0] i_id_md_op,
  input  logic [1:0] i_id_jump,
  input  logic       i_branch_ok,
  input  logic       i_ex_reg_write,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  input  logic       i_mem_mem_read,
  input  logic [4:0] i_mem_rd,
  output logic       o_pc_write,
  output logic       o_hazard,
  output logic       o_branch_bubble,
  output logic       o_branch_go,
  output logic       o_id_ex_bubble,
  output logic       o_md_start,
  output logic       o_md_busy,
  output md_state_t  o_md_state
);

  logic w_ex_match;
  logic w_mem_match;
  logic w_load_stall;
  logic w_br_stall;
  logic w_md_stall;
  logic w_stall;
  logic w_jump_unused;

  assign w_jump_unused = |i_id_jump;

  assign w_ex_match  = reg_match(i_ex_rd,  i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt);
  assign w_mem_match = reg_match(i_mem_rd, i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt);

  assign w_load_stall = i_ex_mem_read & w_ex_match;
  // A load in EX feeding a branch costs two cycles: this EX term first, then
  // the MEM-load term once the load has moved on.
  assign w_br_stall   = i_id_is_branch &
                        ((i_ex_reg_write & w_ex_match) | (i_mem_mem_read & w_mem_match));
  assign w_md_stall   = o_md_busy & (i_id_md_op != MD_NONE);
  assign w_stall      = w_load_stall | w_br_stall | w_md_stall;

  md_sched #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_sched (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_md_op    (i_id_md_op),
    .i_hold     (w_load_stall | w_br_stall),
    .o_md_start (o_md_start),
    .o_md_busy  (o_md_busy),
    .o_state    (o_md_state)
  );

  always_comb begin
    o_pc_write      = 1'b1;
    o_hazard        = 1'b0;
    o_branch_bubble = 1'b0;
    o_branch_go     = 1'b0;
    o_id_ex_bubble  = 1'b0;
    if (!i_reset) begin
      if (w_stall) begin
        o_pc_write      = 1'b0;
        o_id_ex_bubble  = 1'b1;
        o_hazard        = w_load_stall | w_md_stall;
        o_branch_bubble = w_br_stall & ~(w_load_stall | w_md_stall);
      end else begin
        // A hazard always wins over a taken branch; it re-evaluates next cycle.
        o_branch_go     = i_branch_ok;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 32;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic       i_reset = 1'b1;
  logic [4:0] i_id_rs = '0, i_id_rt = '0, i_ex_rd = '0, i_mem_rd = '0;
  logic       i_id_use_rs = 0, i_id_use_rt = 0, i_id_is_branch = 0, i_branch_ok = 0;
  logic [1:0] i_id_md_op = '0, i_id_jump = '0;
  logic       i_ex_reg_write = 0, i_ex_mem_read = 0, i_mem_mem_read = 0;

  logic o_pc_write, o_hazard, o_branch_bubble, o_branch_go, o_id_ex_bubble;
  logic o_md_start, o_md_busy;
  md_state_t o_md_state;

  pipe_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_id_use_rs(i_id_use_rs), .i_id_use_rt(i_id_use_rt),
    .i_id_is_branch(i_id_is_branch), .i_id_md_op(i_id_md_op),
    .i_id_jump(i_id_jump), .i_branch_ok(i_branch_ok),
    .i_ex_reg_write(i_ex_reg_write), .i_ex_mem_read(i_ex_mem_read), .i_ex_rd(i_ex_rd),
    .i_mem_mem_read(i_mem_mem_read), .i_mem_rd(i_mem_rd),
    .o_pc_write(o_pc_write), .o_hazard(o_hazard), .o_branch_bubble(o_branch_bubble),
    .o_branch_go(o_branch_go), .o_id_ex_bubble(o_id_ex_bubble),
    .o_md_start(o_md_start), .o_md_busy(o_md_busy), .o_md_state(o_md_state)
  );

  // ---------------- reference model ----------------
  // The unit is modelled as "busy for every cycle strictly before busy_end".
  int cyc      = 0;
  int busy_end = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected vector: {pc_write, hazard, branch_bubble, branch_go, id_ex_bubble, md_start, md_busy}
  logic [6:0] exp_q[$];
  string      tag_q[$];
  string      cur_tag = "reset";

  function automatic bit uses(input logic [4:0] r);
    if (r == 5'd0) return 0;
    return (i_id_use_rs && r == i_id_rs) || (i_id_use_rt && r == i_id_rt);
  endfunction

  function automatic logic [6:0] model(output bit issue);
    bit busy, ld, br, md, st;
    busy  = (cyc < busy_end);
    issue = 0;
    if (i_reset) return {1'b1, 5'b0, busy};
    ld = i_ex_mem_read && uses(i_ex_rd);
    br = i_id_is_branch && ((i_ex_reg_write && uses(i_ex_rd)) ||
                            (i_mem_mem_read && uses(i_mem_rd)));
    md = busy && (i_id_md_op != 2'b00);
    st = ld || br || md;
    issue = !st && (i_id_md_op == 2'b01 || i_id_md_op == 2'b10);
    if (st) return {1'b0, ld || md, br && !(ld || md), 1'b0, 1'b1, 1'b0, busy};
    return {1'b1, 1'b0, 1'b0, i_branch_ok, 1'b0, issue, busy};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    i_reset = 0; i_id_rs = 0; i_id_rt = 0; i_id_use_rs = 0; i_id_use_rt = 0;
    i_id_is_branch = 0; i_id_md_op = 0; i_id_jump = 0; i_branch_ok = 0;
    i_ex_reg_write = 0; i_ex_mem_read = 0; i_ex_rd = 0; i_mem_mem_read = 0; i_mem_rd = 0;
  endtask

  // Inputs are already applied (just after a posedge); push the expectation,
  // let the cycle complete, then advance the model.
  task automatic step();
    bit issue;
    logic [6:0] e;
    e = model(issue);
    exp_q.push_back(e);
    tag_q.push_back(cur_tag);
    @(posedge i_clk);
    if (i_reset)       busy_end = 0;
    else if (issue)    busy_end = cyc + ((i_id_md_op == 2'b01) ? MULT_N : DIV_N);
    cyc++;
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      logic [6:0] act, e;
      string t;
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      act = {o_pc_write, o_hazard, o_branch_bubble, o_branch_go, o_id_ex_bubble,
             o_md_start, o_md_busy};
      n_cmp++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got=%b expected=%b (pc,haz,bb,go,bub,start,busy)",
                 t, cyc, act, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    i_reset = 1;
    repeat (2) @(posedge i_clk);
    #1;
    cur_tag = "reset_state";
    step();

    // Load-use: lw $3 in EX, add reads rs=3.
    clear_inputs(); cur_tag = "load_use";
    i_ex_mem_read = 1; i_ex_reg_write = 1; i_ex_rd = 3; i_id_rs = 3; i_id_use_rs = 1;
    step();
    i_ex_mem_read = 0; i_ex_reg_write = 0; i_ex_rd = 0; step();

    // Branch after ALU op.
    clear_inputs(); cur_tag = "branch_alu";
    i_ex_reg_write = 1; i_ex_rd = 5; i_id_is_branch = 1; i_id_rt = 5; i_id_use_rt = 1;
    i_branch_ok = 1;
    step();
    i_ex_reg_write = 0; i_ex_rd = 0; step();

    // Branch after load: hazard, then branch bubble, then go.
    clear_inputs(); cur_tag = "branch_load";
    i_ex_mem_read = 1; i_ex_reg_write = 1; i_ex_rd = 5;
    i_id_is_branch = 1; i_id_rt = 5; i_id_use_rt = 1; i_branch_ok = 1;
    step();
    i_ex_mem_read = 0; i_ex_reg_write = 0; i_ex_rd = 0; i_mem_mem_read = 1; i_mem_rd = 5;
    step();
    i_mem_mem_read = 0; i_mem_rd = 0; step();

    // $0 immunity.
    clear_inputs(); cur_tag = "zero_reg";
    i_ex_mem_read = 1; i_ex_reg_write = 1; i_ex_rd = 0; i_id_rs = 0; i_id_use_rs = 1;
    i_id_is_branch = 1; i_mem_mem_read = 1; i_mem_rd = 0;
    step();

    // Divide then mflo waiting on it.
    clear_inputs(); cur_tag = "div_mflo";
    i_id_md_op = MD_DIV; step();
    i_id_md_op = MD_NONE; step();
    i_id_md_op = MD_READ;
    repeat (31) step();
    i_id_md_op = MD_NONE; step();

    // Back-to-back mult; second one waits, first issue held by load-use.
    clear_inputs(); cur_tag = "mult_b2b";
    i_id_md_op = MD_MULT; i_ex_mem_read = 1; i_ex_rd = 7; i_id_rs = 7; i_id_use_rs = 1;
    step();
    i_ex_mem_read = 0; step();
    repeat (6) step();
    i_id_md_op = MD_NONE; repeat (5) step();

    // Reset mid-divide aborts it; pending mfhi proceeds.
    clear_inputs(); cur_tag = "reset_mid_div";
    i_id_md_op = MD_DIV; step();
    i_id_md_op = MD_READ; repeat (9) step();
    i_reset = 1; step();
    i_reset = 0; step();
    step();

    // Randomized traffic with small register numbers to force collisions.
    cur_tag = "random";
    for (int i = 0; i < 2000; i++) begin
      i_reset        = ($urandom_range(0, 199) == 0);
      i_id_rs        = 5'($urandom_range(0, 3));
      i_id_rt        = 5'($urandom_range(0, 3));
      i_id_use_rs    = 1'($urandom_range(0, 1));
      i_id_use_rt    = 1'($urandom_range(0, 1));
      i_id_is_branch = ($urandom_range(0, 3) == 0);
      i_id_md_op     = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : MD_NONE;
      i_id_jump      = 2'($urandom_range(0, 3));
      i_branch_ok    = 1'($urandom_range(0, 1));
      i_ex_reg_write = 1'($urandom_range(0, 1));
      i_ex_mem_read  = ($urandom_range(0, 3) == 0);
      i_ex_rd        = 5'($urandom_range(0, 3));
      i_mem_mem_read = ($urandom_range(0, 3) == 0);
      i_mem_rd       = 5'($urandom_range(0, 3));
      step();
    end

    clear_inputs();
    @(negedge i_clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Decides each cycle whether the PC and the IF/ID register advance, hold or flush, and whether a bubble is injected into ID/EX.
- Covers load-use hazards and branch-operand hazards for branches resolved in ID.
- Owns the HI/LO multiply/divide unit scheduler: a busy counter that stalls dependent mfhi/mflo and back-to-back mult/div.

Parameters:
- MULT_CYCLES, 5: cycles the mult unit is busy after issue (>=2).
- DIV_CYCLES, 32: cycles the div unit is busy after issue (>=2).
- CNT_W, 6: busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_is_branch  in  1  ID instruction is a conditional branch (compare done in ID).
- id_md_op  in  2  00 none, 01 mult, 10 div, 11 mfhi/mflo read.
- id_Jump  in  2  nonzero = jump decoded in ID.
- Branch_ok  in  1  raw branch-taken from the ID comparator.
- ex_RegWrite  in  1  EX instruction writes a register.
- ex_MemRead  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- mem_MemRead  in  1  MEM instruction is a load.
- mem_rd  in  5  MEM destination register.
- PC_write  out  1  1 = PC loads its next value.
- hazard  out  1  1 = IF/ID holds its contents.
- BranchBubble  out  1  1 = IF/ID holds because a branch waits on operands.
- branch_go  out  1  qualified branch-taken, equal to Branch_ok & ~stall; drives IF/ID flush and PC select.
- id_ex_bubble  out  1  1 = ID/EX loads a NOP.
- md_start  out  1  pulses when a mult/div is actually issued.
- md_busy  out  1  mult/div unit is busy (registered).

Behaviour:
- Match rule: match(r) = (r != 0) and ((id_use_rs and r == id_rs) or (id_use_rt and r == id_rt)). Register $0 never causes a hazard.
- Load-use: ex_MemRead and match(ex_rd) -> load_stall.
- Branch-operand hazards, when id_is_branch:
  - ex_RegWrite and match(ex_rd) -> br_stall.
  - mem_MemRead and match(mem_rd) -> br_stall.
  - A load in EX feeding a branch stalls 2 cycles naturally: load_stall/br_stall in the first cycle, then the mem_MemRead term in the second.
- MD hazard: md_stall = md_busy and id_md_op != 00. Covers a new mult/div while busy and mfhi/mflo while busy.
- Combined stall = load_stall | br_stall | md_stall.
- Outputs while stall=1:
  - PC_write = 0, id_ex_bubble = 1, branch_go = 0.
  - hazard = load_stall | md_stall.
  - BranchBubble = br_stall & ~hazard.
- Outputs while stall=0: PC_write = 1, hazard = 0, BranchBubble = 0, id_ex_bubble = 0, branch_go = Branch_ok.
- Jumps: id_Jump is not gated; it is never stalled by branch hazards, but it is stalled by load_stall/md_stall. The IF/ID flush on a jump is the IF/ID block's own job.
- All of the above is combinational, with zero latency from inputs.
- MD FSM, states IDLE and BUSY, counter md_cnt:
  - IDLE, id_md_op=01 (mult), no stall from other sources: md_start=1, md_cnt <= MULT_CYCLES-1, go BUSY.
  - IDLE, id_md_op=10 (div), no stall from other sources: md_start=1, md_cnt <= DIV_CYCLES-1, go BUSY.
  - BUSY: md_cnt decrements each cycle; when md_cnt == 1, next state is IDLE and md_cnt = 0.
  - md_busy = (state == BUSY), registered.
  - An mfhi/mflo in the same cycle the FSM returns to IDLE proceeds with no stall.
  - A mult/div held by load_stall does not issue; md_start stays 0 until it advances.
- Reset (synchronous): state IDLE, md_cnt 0, md_busy 0. While Reset=1, all combinational outputs are forced to PC_write=1, hazard=0, BranchBubble=0, branch_go=0, id_ex_bubble=0, md_start=0.
- Reset mid-divide aborts it; no pending stall survives.
- Simultaneous Branch_ok and a hazard: the hazard wins and the branch re-evaluates next cycle.

Decomposition:
- Shared package (pipe_pkg): MD_NONE/MD_MULT/MD_DIV/MD_READ 2-bit encodings, REG_ZERO constant, MD FSM state encodings.
- One natural sub-module: md_sched (FSM plus counter). The hazard comparators stay in the top level.

Test Plan:
- Load-use: lw $3 in EX (ex_MemRead=1, ex_rd=3), ID add uses rs=3 -> one cycle of hazard=1, PC_write=0, id_ex_bubble=1; next cycle all 0.
- Branch after ALU op: ex_RegWrite=1, ex_rd=5, ID beq rt=5, Branch_ok=1 -> BranchBubble=1, branch_go=0 for 1 cycle; then branch_go=1.
- Branch after load: lw $5 in EX, beq on $5 in ID -> 2 stall cycles (hazard=1, then BranchBubble=1); branch_go is asserted on the 3rd cycle.
- Divide: div issued at cycle 0 -> md_start=1, md_busy=1 for cycles 1..31; mflo in ID at cycle 2 stalls until cycle 32, then proceeds.
- $0 immunity: ex_MemRead=1, ex_rd=0, ID uses rs=0 -> no stall.
- Reset mid-op: assert Reset at cycle 10 of a div -> md_busy=0 the next cycle; a pending mfhi proceeds with no stall.
